// File: rtl/bp_clint_ctrl.sv
// Memory-mapped CLINT: owns mtime, per-core mtimecmp and mipi, and raises the
// machine timer/software interrupts. Serves one single-beat 64b request at a time.
module bp_clint_ctrl #(
  parameter int num_core_p    = 1,
  parameter int paddr_width_p = 40,
  parameter int rtc_div_p     = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_w_i,
  input  logic [paddr_width_p-1:0] req_addr_i,
  input  logic [63:0]              req_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic [63:0]              resp_data_o,
  output logic                     resp_err_o,
  output logic [num_core_p-1:0]    software_irq_o,
  output logic [num_core_p-1:0]    timer_irq_o
);

  localparam int PW = (rtc_div_p > 1) ? $clog2(rtc_div_p) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(rtc_div_p - 1);

  localparam logic [paddr_width_p-1:0] MIPI_BASE  = paddr_width_p'(64'h0000_0000_0030_0000);
  localparam logic [paddr_width_p-1:0] CMP_BASE   = paddr_width_p'(64'h0000_0000_0030_4000);
  localparam logic [paddr_width_p-1:0] MTIME_ADDR = paddr_width_p'(64'h0000_0000_0030_bff8);

  typedef enum logic {
    eReady = 1'b0,
    eResp  = 1'b1
  } state_e;

  state_e                  r_state;
  state_e                  w_state_nxt;

  logic [63:0]             r_mtime;
  logic [PW-1:0]           r_presc;
  logic [63:0]             r_mtimecmp [num_core_p];
  logic [num_core_p-1:0]   r_mipi;
  logic [num_core_p-1:0]   r_timer_irq;
  logic [63:0]             r_resp_data;
  logic                    r_resp_err;

  logic [num_core_p-1:0]   w_mipi_sel;
  logic [num_core_p-1:0]   w_cmp_sel;
  logic                    w_mtime_sel;
  logic                    w_err;
  logic [63:0]             w_rdata;
  logic                    w_accept;
  logic                    w_wr;
  logic                    w_tick;

  // Address decode: exact compares only, so unaligned or out-of-range hits fall to error.
  always_comb begin
    w_mipi_sel  = '0;
    w_cmp_sel   = '0;
    w_mtime_sel = (req_addr_i == MTIME_ADDR);
    for (int i = 0; i < num_core_p; i++) begin
      w_mipi_sel[i] = (req_addr_i == (MIPI_BASE + paddr_width_p'(4 * i)));
      w_cmp_sel[i]  = (req_addr_i == (CMP_BASE  + paddr_width_p'(8 * i)));
    end
    w_err = ~((|w_mipi_sel) | (|w_cmp_sel) | w_mtime_sel);
  end

  always_comb begin
    w_rdata = w_mtime_sel ? r_mtime : 64'd0;
    for (int i = 0; i < num_core_p; i++) begin
      if (w_mipi_sel[i]) w_rdata = {63'd0, r_mipi[i]};
      if (w_cmp_sel[i])  w_rdata = r_mtimecmp[i];
    end
  end

  assign w_accept = req_v_i & req_ready_o;
  assign w_wr     = w_accept & req_w_i & ~w_err;
  assign w_tick   = (r_presc == PRESC_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= eReady;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = 1'b0;
    resp_v_o    = 1'b0;
    case (r_state)
      eReady: begin
        req_ready_o = 1'b1;
        if (req_v_i) w_state_nxt = eResp;
      end
      eResp: begin
        resp_v_o = 1'b1;
        if (resp_yumi_i) w_state_nxt = eReady;
      end
      default: w_state_nxt = eReady;
    endcase
  end

  // A software write to mtime beats a coincident tick and restarts the prescaler.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mtime <= 64'd0;
      r_presc <= '0;
    end else if (w_wr & w_mtime_sel) begin
      r_mtime <= req_data_i;
      r_presc <= '0;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mipi <= '0;
      for (int i = 0; i < num_core_p; i++) r_mtimecmp[i] <= '1;
    end else begin
      for (int i = 0; i < num_core_p; i++) begin
        if (w_wr & w_mipi_sel[i]) r_mipi[i]     <= req_data_i[0];
        if (w_wr & w_cmp_sel[i])  r_mtimecmp[i] <= req_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_timer_irq <= '0;
    end else begin
      for (int i = 0; i < num_core_p; i++) r_timer_irq[i] <= (r_mtime >= r_mtimecmp[i]);
    end
  end

  // Response captures pre-update register contents at the accept edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_resp_data <= 64'd0;
      r_resp_err  <= 1'b0;
    end else if (w_accept) begin
      r_resp_data <= (req_w_i | w_err) ? 64'd0 : w_rdata;
      r_resp_err  <= w_err;
    end
  end

  assign resp_data_o    = r_resp_data;
  assign resp_err_o     = r_resp_err;
  assign software_irq_o = r_mipi;
  assign timer_irq_o    = r_timer_irq;

endmodule

// File: tb/tb_bp_clint_ctrl.sv
// Directed bench for bp_clint_ctrl: one task per feature, inline expected values.
module tb_bp_clint_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_v, req_ready, req_w, resp_v, yumi, resp_err;
  logic [39:0] req_addr;
  logic [63:0] req_data, resp_data;
  logic [0:0]  sw_irq, tm_irq;

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned n_edge = 0;
  int unsigned base = 0;

  localparam logic [39:0] A_MIPI0 = 40'h00_0030_0000;
  localparam logic [39:0] A_CMP0  = 40'h00_0030_4000;
  localparam logic [39:0] A_CMP1  = 40'h00_0030_4008;
  localparam logic [39:0] A_MTIME = 40'h00_0030_bff8;
  localparam logic [39:0] A_BAD   = 40'h00_0030_0100;

  always #5 clk = ~clk;
  always @(posedge clk) n_edge <= n_edge + 1;

  bp_clint_ctrl #(.num_core_p(1), .paddr_width_p(40), .rtc_div_p(8)) dut (
    .clk_i(clk), .reset_i(rst), .req_v_i(req_v), .req_ready_o(req_ready),
    .req_w_i(req_w), .req_addr_i(req_addr), .req_data_i(req_data),
    .resp_v_o(resp_v), .resp_yumi_i(yumi), .resp_data_o(resp_data),
    .resp_err_o(resp_err), .software_irq_o(sw_irq), .timer_irq_o(tm_irq)
  );

  task automatic apply_reset();
    rst = 1'b1; req_v = 1'b0; req_w = 1'b0; yumi = 1'b0;
    req_addr = '0; req_data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = n_edge;
  endtask

  // Advance to the falling edge after rising edge number 'target' since reset release.
  task automatic wait_to(input int unsigned target);
    int guard = 0;
    while ((n_edge - base) < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if ((n_edge - base) != target) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_to: at edge %0d, required edge %0d", n_edge - base, target);
    end
  endtask

  task automatic send(input logic w, input logic [39:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic re, output logic rv,
                      output logic rdy);
    rdy = req_ready;
    req_v = 1'b1; req_w = w; req_addr = a; req_data = d;
    @(posedge clk);
    @(negedge clk);
    req_v = 1'b0; req_w = 1'b0; req_addr = '0; req_data = '0;
    rv = resp_v; rd = resp_data; re = resp_err;
  endtask

  task automatic ack();
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_v = 1'b0; req_w = 1'b0; yumi = 1'b0;
    req_addr = '0; req_data = '0;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b need 1", req_ready); end
    n_cmp++; if (resp_v !== 1'b0) begin n_bad++; $display("FAIL rst_resp_v: got %b need 0", resp_v); end
    n_cmp++; if (resp_data !== 64'd0) begin n_bad++; $display("FAIL rst_data: got %h need 0", resp_data); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b need 0", resp_err); end
    n_cmp++; if (sw_irq !== 1'b0) begin n_bad++; $display("FAIL rst_sw_irq: got %b need 0", sw_irq); end
    n_cmp++; if (tm_irq !== 1'b0) begin n_bad++; $display("FAIL rst_tm_irq: got %b need 0", tm_irq); end
    apply_reset();
  endtask

  task automatic test_mtime_read();
    logic [63:0] rd; logic re, rv, rdy;
    apply_reset();
    wait_to(40);
    send(1'b0, A_MTIME, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (rdy !== 1'b1) begin n_bad++; $display("FAIL t1_ready: got %b need 1", rdy); end
    n_cmp++; if (rv !== 1'b1) begin n_bad++; $display("FAIL t1_resp_v: got %b need 1", rv); end
    n_cmp++; if (rd !== 64'd5) begin n_bad++; $display("FAIL t1_mtime: got %h need 5", rd); end
    n_cmp++; if (re !== 1'b0) begin n_bad++; $display("FAIL t1_err: got %b need 0", re); end
    ack();
  endtask

  task automatic test_timer();
    logic [63:0] rd; logic re, rv, rdy;
    apply_reset();
    send(1'b1, A_CMP0, 64'h10, rd, re, rv, rdy);
    n_cmp++; if (rd !== 64'd0 || re !== 1'b0) begin n_bad++; $display("FAIL t2_wr_resp: got %h/%b need 0/0", rd, re); end
    ack();
    wait_to(128);
    n_cmp++; if (tm_irq !== 1'b0) begin n_bad++; $display("FAIL t2_irq_before: got %b need 0", tm_irq); end
    @(negedge clk);
    n_cmp++; if (tm_irq !== 1'b1) begin n_bad++; $display("FAIL t2_irq_at16: got %b need 1", tm_irq); end
    send(1'b1, A_CMP0, 64'hFFFF_FFFF_FFFF_FFFF, rd, re, rv, rdy);
    n_cmp++; if (tm_irq !== 1'b1) begin n_bad++; $display("FAIL t2_irq_lag: got %b need 1", tm_irq); end
    ack();
    n_cmp++; if (tm_irq !== 1'b0) begin n_bad++; $display("FAIL t2_irq_drop: got %b need 0", tm_irq); end
  endtask

  task automatic test_software_irq();
    logic [63:0] rd; logic re, rv, rdy;
    send(1'b1, A_MIPI0, 64'hFFFF_FFFF, rd, re, rv, rdy);
    n_cmp++; if (sw_irq !== 1'b1) begin n_bad++; $display("FAIL t3_sw_set: got %b need 1", sw_irq); end
    ack();
    send(1'b0, A_MIPI0, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (rd !== 64'd1) begin n_bad++; $display("FAIL t3_readback1: got %h need 1", rd); end
    ack();
    send(1'b1, A_MIPI0, 64'd0, rd, re, rv, rdy);
    ack();
    n_cmp++; if (sw_irq !== 1'b0) begin n_bad++; $display("FAIL t3_sw_clr: got %b need 0", sw_irq); end
    send(1'b0, A_MIPI0, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (rd !== 64'd0) begin n_bad++; $display("FAIL t3_readback0: got %h need 0", rd); end
    ack();
  endtask

  task automatic test_decode_err();
    logic [63:0] rd; logic re, rv, rdy;
    send(1'b0, A_BAD, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (re !== 1'b1 || rd !== 64'd0) begin n_bad++; $display("FAIL t4_bad_rd: got %b/%h need 1/0", re, rd); end
    ack();
    send(1'b0, A_CMP1, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (re !== 1'b1 || rd !== 64'd0) begin n_bad++; $display("FAIL t4_cmp1_rd: got %b/%h need 1/0", re, rd); end
    ack();
    send(1'b1, A_CMP1, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (re !== 1'b1) begin n_bad++; $display("FAIL t4_cmp1_wr: got %b need 1", re); end
    ack();
    send(1'b1, A_BAD, 64'd1, rd, re, rv, rdy);
    ack();
    n_cmp++; if (sw_irq !== 1'b0) begin n_bad++; $display("FAIL t4_no_side_sw: got %b need 0", sw_irq); end
    send(1'b0, A_CMP0, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (re !== 1'b0 || rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL t4_cmp0_kept: got %b/%h need 0/ffffffffffffffff", re, rd); end
    ack();
  endtask

  task automatic test_mtime_wrap();
    logic [63:0] rd; logic re, rv, rdy;
    apply_reset();
    wait_to(7);
    send(1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFF, rd, re, rv, rdy);
    ack();
    send(1'b0, A_MTIME, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL t5_write_wins: got %h need ffffffffffffffff", rd); end
    ack();
    wait_to(15);
    send(1'b0, A_MTIME, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (rd !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_bad++; $display("FAIL t5_pre_wrap: got %h need ffffffffffffffff", rd); end
    ack();
    send(1'b0, A_MTIME, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (rd !== 64'd0) begin n_bad++; $display("FAIL t5_wrapped: got %h need 0", rd); end
    ack();
    send(1'b1, A_MTIME, 64'h100, rd, re, rv, rdy);
    ack();
    wait_to(27);
    send(1'b0, A_MTIME, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (rd !== 64'h100) begin n_bad++; $display("FAIL t5_presc_clr: got %h need 100", rd); end
    ack();
    send(1'b0, A_MTIME, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (rd !== 64'h101) begin n_bad++; $display("FAIL t5_tick_after: got %h need 101", rd); end
    ack();
  endtask

  task automatic test_hold_and_reset();
    logic [63:0] rd; logic re, rv, rdy;
    apply_reset();
    wait_to(20);
    send(1'b0, A_MTIME, 64'd0, rd, re, rv, rdy);
    req_v = 1'b1; req_w = 1'b1; req_addr = A_MIPI0; req_data = 64'd1;
    for (int k = 0; k < 10; k++) begin
      n_cmp++; if (resp_v !== 1'b1) begin n_bad++; $display("FAIL t6_hold_v[%0d]: got %b need 1", k, resp_v); end
      n_cmp++; if (resp_data !== 64'd2) begin n_bad++; $display("FAIL t6_hold_data[%0d]: got %h need 2", k, resp_data); end
      n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL t6_hold_ready[%0d]: got %b need 0", k, req_ready); end
      @(negedge clk);
    end
    n_cmp++; if (sw_irq !== 1'b0) begin n_bad++; $display("FAIL t6_req_ignored: got %b need 0", sw_irq); end
    req_v = 1'b0; req_w = 1'b0; req_addr = '0; req_data = '0;
    rst = 1'b1;
    #1;
    n_cmp++; if (resp_v !== 1'b0) begin n_bad++; $display("FAIL t6_rst_v: got %b need 0", resp_v); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL t6_rst_ready: got %b need 1", req_ready); end
    n_cmp++; if (resp_data !== 64'd0) begin n_bad++; $display("FAIL t6_rst_data: got %h need 0", resp_data); end
    @(negedge clk);
    rst = 1'b0;
    base = n_edge;
    send(1'b0, A_MTIME, 64'd0, rd, re, rv, rdy);
    n_cmp++; if (rd !== 64'd0) begin n_bad++; $display("FAIL t6_mtime_cleared: got %h need 0", rd); end
    ack();
    yumi = 1'b1;
    @(negedge clk);
    yumi = 1'b0;
    n_cmp++; if (resp_v !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL t6_stray_yumi: got v=%b rdy=%b need 0/1", resp_v, req_ready); end
  endtask

  initial begin
    test_reset();
    test_mtime_read();
    test_timer();
    test_software_irq();
    test_decode_err();
    test_mtime_wrap();
    test_hold_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
